// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage of the 5-stage RV32 core. It holds the PC, runs the
//   instruction-memory request/ack handshake and owns the IF/ID pipeline
//   register that feeds decode and the load-use hazard detector.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   NOP_INSTR   instruction placed in IF/ID on reset or flush (addi x0,x0,0)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   stall        load-use stall; freezes the PC and IF/ID
//   redirect     taken branch/jump from EX; flushes IF/ID and loads redirect_pc
//   redirect_pc  redirect target (low two bits ignored)
//   imem_req     fetch request, held until imem_ack
//   imem_addr    fetch address, stable while imem_req is high
//   imem_ack     memory accepted the request; imem_rdata valid in the same cycle
//   imem_rdata   fetched instruction
//   if_id_pc     PC of the instruction in IF/ID
//   if_id_instr  instruction in IF/ID
//   if_id_valid  IF/ID holds a real instruction (0 = bubble)

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  // IDLE  : one-cycle pause after reset before the first request
  // FETCH : request outstanding for the address in addr_q
  // HOLD  : a fetched instruction is parked in the skid buffer during a stall
  // DROP  : waiting out the ack of a request made obsolete by a redirect
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;

  // Targets are word aligned; the low bits of the EX result are simply masked.
  assign redirect_tgt = redirect_pc & ~32'd3;
  assign pc_plus4     = pc + 32'd4;

  // The address is registered separately from pc because in DROP the pc
  // already points at the redirect target while the old request must stay
  // on the bus unchanged until it is acknowledged.
  assign imem_addr = addr_q;

  // Single sequencer: reset first, then redirect (which beats stall), then
  // the normal per-state handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      imem_req    <= 1'b0;
      skid_pc     <= 32'd0;
      skid_instr  <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_tgt;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      // A request still waiting for its ack cannot be withdrawn, so keep it
      // on the bus and throw its data away later; otherwise start at once.
      if (imem_req && !imem_ack) begin
        state <= DROP;
      end else begin
        state    <= FETCH;
        imem_req <= 1'b1;
        addr_q   <= redirect_tgt;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          addr_q   <= pc;
        end
        FETCH: begin
          if (imem_ack) begin
            pc     <= pc_plus4;
            addr_q <= pc_plus4;
            if (stall) begin
              // Decode cannot take the instruction; park it and pause requests.
              skid_pc    <= pc;
              skid_instr <= imem_rdata;
              imem_req   <= 1'b0;
              state      <= HOLD;
            end else begin
              if_id_pc    <= pc;
              if_id_instr <= imem_rdata;
              if_id_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_pc    <= skid_pc;
            if_id_instr <= skid_instr;
            if_id_valid <= 1'b1;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        DROP: begin
          if (imem_ack) begin
            addr_q <= pc;
            state  <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed and random stimulus for fetch_stage, checked every cycle against a
//   transaction-level model of the fetch stage: a pending-request record, a
//   discard flag and a queue standing in for the skid buffer. A second instance
//   with RESET_PC at the top of the address space checks PC wraparound.

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;

  logic        w_imem_req, w_if_id_valid;
  logic [31:0] w_imem_addr, w_if_id_pc, w_if_id_instr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_addr;
  logic        m_req, m_idle, m_discard;
  logic [63:0] m_skid[$];
  logic [31:0] e_pc, e_instr;
  logic        e_valid;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_pc(w_if_id_pc),
    .if_id_instr(w_if_id_instr), .if_id_valid(w_if_id_valid)
  );

  // One clock of the fetch stage described as transactions: what request is
  // on the bus, whether its data is wanted, and where accepted data goes.
  task automatic modelStep();
    logic accepted;
    accepted = m_req && imem_ack;
    if (reset) begin
      m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_idle = 1'b1;
      m_discard = 1'b0; m_skid.delete();
      e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
    end else if (redirect) begin
      e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
      m_skid.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      m_idle = 1'b0;
      if (m_req && !imem_ack) begin
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0; m_req = 1'b1; m_addr = m_pc;
      end
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end else if (m_skid.size() > 0) begin
      if (!stall) begin
        {e_pc, e_instr} = m_skid.pop_front();
        e_valid = 1'b1; m_req = 1'b1; m_addr = m_pc;
      end
    end else if (accepted) begin
      if (m_discard) begin
        m_discard = 1'b0; m_addr = m_pc;
      end else begin
        if (stall) begin
          m_skid.push_back({m_addr, imem_rdata});
          m_req = 1'b0;
        end else begin
          e_pc = m_addr; e_instr = imem_rdata; e_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
        m_addr = m_pc;
      end
    end
  endtask

  // One immediate-assertion comparison; counts and reports failures.
  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    checkEq("imem_addr", imem_addr, m_addr);
    checkEq("if_id_pc", if_id_pc, e_pc);
    checkEq("if_id_instr", if_id_instr, e_instr);
    checkEq("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  // Drive one cycle of inputs away from the edge, advance the model on the
  // edge, then compare just after it.
  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic ak,
                               input logic [31:0] rdata);
    @(negedge clk);
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    imem_ack = ak; imem_rdata = rdata;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] addrData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset, then back-to-back acks; the wrap instance must step FFFFFFFC -> 0.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkEq("wrap_reset_req", {31'd0, w_imem_req}, 32'd0);
    checkEq("wrap_reset_instr", w_if_id_instr, NOP);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    checkEq("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    checkEq("wrap_second_addr", w_imem_addr, 32'h0000_0000);
    checkEq("wrap_first_pc", w_if_id_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));

    // Stall on the ack at pc=8: instruction parked, requests paused, released.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    applyStimulus(0, 1, 0, 0, 1, addrData(m_addr));
    checkEq("hold_if_id_pc", if_id_pc, 32'h4);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("release_if_id_pc", if_id_pc, 32'h8);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));

    // Redirect coinciding with an ack: data dropped, fetch restarts at 0x100.
    applyStimulus(0, 0, 1, 32'h0000_0103, 1, 32'hDEAD_BEEF);
    checkEq("redir_ack_addr", imem_addr, 32'h0000_0100);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));

    // Redirect with the request still pending, then a late ack that is dropped;
    // finally stall and redirect together.
    applyStimulus(0, 0, 1, 32'h0000_0202, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    checkEq("drop_then_target", imem_addr, 32'h0000_0200);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));
    applyStimulus(0, 1, 1, 32'h0000_0300, 1, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));

    // Reset from HOLD and from DROP while stall is high.
    applyStimulus(0, 1, 0, 0, 1, addrData(m_addr));
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0400, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, addrData(m_addr));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 4) == 0,
                    ($urandom % 12) == 0, $urandom,
                    ($urandom % 4) != 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
